ram_wport_sched: RTL and testbench



---
 rtl/ram_wport_sched.sv | 133 +++++++++++++
 tb/tb_ram_wport_sched.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ram_wport_sched.sv
// Write-port scheduler for a single-write-port register RAM: round-robin among
// three writeback requesters, plus a clear sequencer that zeroes every address.
module ram_wport_sched #(
    parameter int bit_width  = 16,
    parameter int addr_width = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gwe,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  req2,
    input  logic [addr_width-1:0] addr0,
    input  logic [addr_width-1:0] addr1,
    input  logic [addr_width-1:0] addr2,
    input  logic [bit_width-1:0]  data0,
    input  logic [bit_width-1:0]  data1,
    input  logic [bit_width-1:0]  data2,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  gnt2,
    input  logic                  clr_start,
    output logic [addr_width-1:0] wsel,
    output logic [bit_width-1:0]  wdata,
    output logic                  we,
    output logic                  busy,
    output logic                  clr_done
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state_reg, state_next;
    logic [1:0]            rr_ptr_reg, rr_ptr_next;
    logic [addr_width-1:0] clr_cnt_reg, clr_cnt_next;
    logic                  clr_done_reg, clr_done_next;

    logic [2:0]            req_vec;
    logic [2:0]            gnt_vec;
    logic [addr_width-1:0] addr_arr [3];
    logic [bit_width-1:0]  data_arr [3];
    logic                  grant_valid;
    logic [1:0]            win_idx;
    logic [2:0]            cand;

    assign req_vec     = {req2, req1, req0};
    assign addr_arr[0] = addr0;
    assign addr_arr[1] = addr1;
    assign addr_arr[2] = addr2;
    assign data_arr[0] = data0;
    assign data_arr[1] = data1;
    assign data_arr[2] = data2;

    assign gnt0 = gnt_vec[0];
    assign gnt1 = gnt_vec[1];
    assign gnt2 = gnt_vec[2];

    // Everything visible to the RAM is forced quiet while reset is held.
    always_comb begin
        gnt_vec     = '0;
        grant_valid = 1'b0;
        win_idx     = 2'd0;
        cand        = 3'd0;
        we          = 1'b0;
        wsel        = '0;
        wdata       = '0;
        busy        = 1'b0;
        if (rst) begin
            if (state_reg == CLEAR) begin
                busy = 1'b1;
                we   = 1'b1;
                wsel = clr_cnt_reg;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    cand = {1'b0, rr_ptr_reg} + 3'(k);
                    if (cand >= 3'd3)
                        cand = cand - 3'd3;
                    if (!grant_valid && req_vec[cand[1:0]]) begin
                        grant_valid = 1'b1;
                        win_idx     = cand[1:0];
                    end
                end
                if (grant_valid) begin
                    gnt_vec[win_idx] = 1'b1;
                    we               = 1'b1;
                    wsel             = addr_arr[win_idx];
                    wdata            = data_arr[win_idx];
                end
            end
        end
    end

    assign clr_done = rst & clr_done_reg;

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        clr_cnt_next  = clr_cnt_reg;
        clr_done_next = clr_done_reg;
        if (gwe) begin
            clr_done_next = 1'b0;
            if (state_reg == IDLE) begin
                if (grant_valid)
                    rr_ptr_next = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
                if (clr_start) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end
            end else begin
                if (&clr_cnt_reg) begin
                    state_next    = IDLE;
                    clr_done_next = 1'b1;
                end else begin
                    clr_cnt_next = clr_cnt_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= 2'd0;
            clr_cnt_reg  <= '0;
            clr_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            clr_cnt_reg  <= clr_cnt_next;
            clr_done_reg <= clr_done_next;
        end
    end

endmodule

// File: tb/tb_ram_wport_sched.sv
// Directed bench for ram_wport_sched; a bench-side RAM captures the committed
// writes so arbitration and clear results can be checked by content.
module tb_ram_wport_sched;

    localparam int BW = 16;
    localparam int AW = 3;
    localparam int RS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          gwe;
    logic          req0, req1, req2;
    logic [AW-1:0] addr0, addr1, addr2;
    logic [BW-1:0] data0, data1, data2;
    logic          gnt0, gnt1, gnt2;
    logic          clr_start;
    logic [AW-1:0] wsel;
    logic [BW-1:0] wdata;
    logic          we;
    logic          busy;
    logic          clr_done;

    logic [BW-1:0] ram [RS];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_wport_sched #(.bit_width(BW), .addr_width(AW)) dut (
        .clk(clk), .rst(rst), .gwe(gwe),
        .req0(req0), .req1(req1), .req2(req2),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .data0(data0), .data1(data1), .data2(data2),
        .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
        .clr_start(clr_start), .wsel(wsel), .wdata(wdata), .we(we),
        .busy(busy), .clr_done(clr_done)
    );

    always @(posedge clk)
        if (rst && gwe && we)
            ram[wsel] <= wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("check %s: %h", tag, obs);
        end
    endtask

    function automatic logic [31:0] gnts();
        return {29'd0, gnt2, gnt1, gnt0};
    endfunction

    initial begin
        for (int i = 0; i < RS; i++) ram[i] = '0;
        rst = 1'b0; gwe = 1'b0; clr_start = 1'b0;
        req0 = 1'b1; req1 = 1'b1; req2 = 1'b1;
        addr0 = 3'd1; addr1 = 3'd2; addr2 = 3'd3;
        data0 = 16'h1111; data1 = 16'h2222; data2 = 16'h3333;

        // reset holds everything quiet even with all requests up
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnts(), 32'h0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_wsel", {29'd0, wsel}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, clr_done}, 32'd0);

        rst = 1'b1; gwe = 1'b1;
        #1;
        chk("post_rst_gnt", gnts(), 32'h1);
        chk("post_rst_wsel", {29'd0, wsel}, 32'd1);

        // round robin: grants 0,1,2,0
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_gnt%0d", i), gnts(), 32'(1 << (i % 3)));
            chk($sformatf("rr_wsel%0d", i), {29'd0, wsel}, 32'((i % 3) + 1));
            @(negedge clk);
        end
        chk("ram1", {16'd0, ram[1]}, 32'h1111);
        chk("ram2", {16'd0, ram[2]}, 32'h2222);
        chk("ram3", {16'd0, ram[3]}, 32'h3333);

        // gwe stall with only req1 (rr_ptr now 1)
        req0 = 1'b0; req2 = 1'b0; addr1 = 3'd5; data1 = 16'hAAAA; gwe = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall_gnt%0d", i), gnts(), 32'h2);
            chk($sformatf("stall_ram%0d", i), {16'd0, ram[5]}, 32'h0);
        end
        gwe = 1'b1;
        @(negedge clk);
        chk("stall_commit", {16'd0, ram[5]}, 32'hAAAA);
        gwe = 1'b0; req0 = 1'b1; req1 = 1'b1; req2 = 1'b1;
        #1;
        chk("rr_after_stall", gnts(), 32'h4);

        // clear with req2 pending; the grant at the clr_start edge still writes
        for (int i = 0; i < RS; i++) ram[i] = 16'hFFFF;
        req0 = 1'b0; req1 = 1'b0; data2 = 16'h5A5A;
        gwe = 1'b1; clr_start = 1'b1;
        #1;
        chk("clr_start_gnt", gnts(), 32'h4);
        @(negedge clk);
        clr_start = 1'b0;
        chk("clr_pre_ram3", {16'd0, ram[3]}, 32'h5A5A);
        for (int k = 0; k < RS; k++) begin
            chk($sformatf("clr_busy%0d", k), {31'd0, busy}, 32'd1);
            chk($sformatf("clr_wsel%0d", k), {29'd0, wsel}, 32'(k));
            chk($sformatf("clr_gnt%0d", k), gnts(), 32'h0);
            chk($sformatf("clr_we%0d", k), {31'd0, we}, 32'd1);
            @(negedge clk);
        end
        chk("clr_end_busy", {31'd0, busy}, 32'd0);
        chk("clr_done_hi", {31'd0, clr_done}, 32'd1);
        chk("clr_end_gnt", gnts(), 32'h4);
        for (int i = 0; i < RS; i++)
            chk($sformatf("clr_ram%0d", i), {16'd0, ram[i]}, 32'h0);
        req2 = 1'b0;
        @(negedge clk);
        chk("clr_done_lo", {31'd0, clr_done}, 32'd0);

        // clear under alternating gwe
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        begin
            int ones = 0;
            for (int c = 0; c < 16; c++) begin
                gwe = (c % 2 == 0);
                #1;
                chk($sformatf("stc_busy%0d", c), {31'd0, busy}, {31'd0, ones < RS});
                chk($sformatf("stc_wsel%0d", c), {29'd0, wsel}, (ones < RS) ? 32'(ones) : 32'd0);
                chk($sformatf("stc_done%0d", c), {31'd0, clr_done}, {31'd0, ones == RS});
                @(negedge clk);
                if (gwe) ones++;
            end
        end
        gwe = 1'b1;
        @(negedge clk);
        chk("stc_done_lo", {31'd0, clr_done}, 32'd0);

        // reset in the middle of a clear
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_wsel", {29'd0, wsel}, 32'd4);
        rst = 1'b0;
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_we", {31'd0, we}, 32'd0);
        @(negedge clk);
        rst = 1'b1; req0 = 1'b1;
        #1;
        chk("mid_rel_busy", {31'd0, busy}, 32'd0);
        chk("mid_rel_gnt", gnts(), 32'h1);
        repeat (2) begin
            @(negedge clk);
            chk("mid_no_done", {31'd0, clr_done}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
